// File: rtl/snn_axi_pkg.sv
// Shared types and constants for the spiking-network AXI4-Lite fetch path.
// Holds the fetch FSM state encoding, AXI response codes and the weight address map helper.
package snn_axi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        OUT  = 2'd3
    } fetch_state_t;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    localparam int unsigned WEIGHT_W = 16;
    localparam int unsigned INDEX_W  = 16;

    // Weights are one per 32-bit word; the byte address wraps at 32 bits.
    function automatic logic [31:0] weight_addr(input logic [31:0] base,
                                                 input logic [INDEX_W-1:0] idx);
        return base + {14'b0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/synapse_weight_fetcher_if.sv
// Bundles the spike input, AXI4-Lite read channels and weight output stream of the fetcher.
// The master modport is the fetcher's view; the slave modport is the surrounding system's view.
interface synapse_weight_fetcher_if #(
    parameter int unsigned CNT_W = 8
);
    logic             spk_valid;
    logic             spk_ready;
    logic [15:0]      spk_base;
    logic [CNT_W-1:0] spk_count;

    logic [31:0]      m_axi_araddr;
    logic             m_axi_arvalid;
    logic             m_axi_arready;
    logic [31:0]      m_axi_rdata;
    logic [1:0]       m_axi_rresp;
    logic             m_axi_rvalid;
    logic             m_axi_rready;

    logic             wt_valid;
    logic             wt_ready;
    logic [15:0]      wt_data;
    logic [15:0]      wt_index;
    logic             wt_last;
    logic             wt_err;

    modport master (
        input  spk_valid, spk_base, spk_count,
        output spk_ready,
        output m_axi_araddr, m_axi_arvalid, m_axi_rready,
        input  m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        output wt_valid, wt_data, wt_index, wt_last, wt_err,
        input  wt_ready
    );

    modport slave (
        output spk_valid, spk_base, spk_count,
        input  spk_ready,
        input  m_axi_araddr, m_axi_arvalid, m_axi_rready,
        output m_axi_arready, m_axi_rdata, m_axi_rresp, m_axi_rvalid,
        input  wt_valid, wt_data, wt_index, wt_last, wt_err,
        output wt_ready
    );

endinterface

// File: rtl/synapse_weight_fetcher.sv
// Spike-driven AXI4-Lite read master: one single-beat read per synapse of an accepted spike
// event, one read outstanding at a time, weights streamed out tagged with their synapse index.
module synapse_weight_fetcher
    import snn_axi_pkg::*;
#(
    parameter int unsigned NUM_SYNAPSES = 214,
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    synapse_weight_fetcher_if.master bus,
    output logic                     busy,
    output logic [15:0]              err_count
);

    fetch_state_t         state_q, state_d;
    logic                 started_q, started_d;
    logic [INDEX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]     rem_q, rem_d;
    logic [31:0]          araddr_q, araddr_d;
    logic [WEIGHT_W-1:0]  wt_data_q, wt_data_d;
    logic [INDEX_W-1:0]   wt_index_q, wt_index_d;
    logic                 wt_last_q, wt_last_d;
    logic                 wt_err_q, wt_err_d;
    logic [15:0]          err_count_q, err_count_d;
    logic                 spk_ready;

    // Range errors come back from the slave as SLVERR, so neither the upper data bits nor the bound drive logic.
    logic unused_ok;
    assign unused_ok = ^{bus.m_axi_rdata[31:16], (32'(idx_q) >= NUM_SYNAPSES)};

    assign spk_ready         = (state_q == IDLE) && started_q;
    assign bus.spk_ready     = spk_ready;
    assign bus.m_axi_arvalid = (state_q == ADDR);
    assign bus.m_axi_araddr  = araddr_q;
    assign bus.m_axi_rready  = (state_q == DATA);
    assign bus.wt_valid      = (state_q == OUT);
    assign bus.wt_data       = wt_data_q;
    assign bus.wt_index      = wt_index_q;
    assign bus.wt_last       = wt_last_q;
    assign bus.wt_err        = wt_err_q;
    assign busy              = (state_q != IDLE);
    assign err_count         = err_count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            started_q   <= 1'b0;
            idx_q       <= '0;
            rem_q       <= '0;
            araddr_q    <= '0;
            wt_data_q   <= '0;
            wt_index_q  <= '0;
            wt_last_q   <= 1'b0;
            wt_err_q    <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            started_q   <= started_d;
            idx_q       <= idx_d;
            rem_q       <= rem_d;
            araddr_q    <= araddr_d;
            wt_data_q   <= wt_data_d;
            wt_index_q  <= wt_index_d;
            wt_last_q   <= wt_last_d;
            wt_err_q    <= wt_err_d;
            err_count_q <= err_count_d;
        end
    end

    // The address is registered on entry to ADDR so it holds steady for the whole AR handshake.
    always_comb begin
        state_d     = state_q;
        started_d   = 1'b1;
        idx_d       = idx_q;
        rem_d       = rem_q;
        araddr_d    = araddr_q;
        wt_data_d   = wt_data_q;
        wt_index_d  = wt_index_q;
        wt_last_d   = wt_last_q;
        wt_err_d    = wt_err_q;
        err_count_d = err_count_q;

        unique case (state_q)
            IDLE: begin
                if (bus.spk_valid && spk_ready && (bus.spk_count != '0)) begin
                    idx_d    = bus.spk_base;
                    rem_d    = bus.spk_count;
                    araddr_d = weight_addr(ADDR_BASE, bus.spk_base);
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                if (bus.m_axi_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bus.m_axi_rvalid) begin
                    wt_data_d  = bus.m_axi_rdata[15:0];
                    wt_err_d   = (bus.m_axi_rresp != AXI_RESP_OKAY);
                    wt_index_d = idx_q;
                    wt_last_d  = (rem_q == CNT_W'(1));
                    if ((bus.m_axi_rresp != AXI_RESP_OKAY) && (err_count_q != 16'hFFFF)) begin
                        err_count_d = err_count_q + 16'd1;
                    end
                    state_d = OUT;
                end
            end
            OUT: begin
                if (bus.wt_ready) begin
                    if (rem_q == CNT_W'(1)) begin
                        state_d = IDLE;
                    end else begin
                        idx_d    = idx_q + 16'd1;
                        rem_d    = rem_q - CNT_W'(1);
                        araddr_d = weight_addr(ADDR_BASE, idx_q + 16'd1);
                        state_d  = ADDR;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: doc/synapse_weight_fetcher.md
# synapse_weight_fetcher

- Spike-driven AXI4-Lite read master that sits directly upstream of the synaptic weight memory's read channel.
- On each accepted presynaptic spike event (base synapse index plus fan-out count), it issues one AXI4-Lite single-beat read per synapse and streams the returned 16-bit weights, tagged with synapse index, to the neuron update stage.
- At most one read is outstanding at a time, matching the memory's single-transaction slave.

## Interface
- NUM_SYNAPSES, 214, number of valid weight entries; index ≥ this is flagged as error.
- ADDR_BASE, 32'h0000_0000, byte address of weight 0 in the slave map.
- CNT_W, 8, width of fan-out count.

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- spk_valid  in  1  spike event valid
- spk_ready  out  1  event accepted when spk_valid & spk_ready
- spk_base  in  16  first synapse index of fan-out
- spk_count  in  CNT_W  number of consecutive synapses (0 = drop)
- m_axi_araddr  out  32  read address
- m_axi_arvalid  out  1  read address valid
- m_axi_arready  in  1  read address ready
- m_axi_rdata  in  32  read data; bits [15:0] are the weight
- m_axi_rresp  in  2  read response
- m_axi_rvalid  in  1  read data valid
- m_axi_rready  out  1  read data ready
- wt_valid  out  1  weight output valid
- wt_ready  in  1  downstream ready
- wt_data  out  16  weight (two's complement, passed through)
- wt_index  out  16  synapse index of wt_data
- wt_last  out  1  last weight of current event
- wt_err  out  1  rresp != OKAY for this weight
- busy  out  1  high in any state except IDLE
- err_count  out  16  saturating count of non-OKAY responses

## Operation
- States:
  - IDLE: spk_ready=1. On handshake with spk_count≠0, latch idx=spk_base and rem=spk_count, then go to ADDR. With spk_count=0, accept and stay in IDLE.
  - ADDR: arvalid=1, araddr = ADDR_BASE + {idx,2'b00}, 32-bit wrap. Address is stable while arvalid is high. arready → DATA.
  - DATA: rready=1. On rvalid, latch:
    - wt_data = rdata[15:0]
    - wt_err = (rresp≠2'b00)
    - wt_index = idx
    - wt_last = (rem==1)
    - then go to OUT.
  - OUT: wt_valid=1 with all wt_* stable until wt_ready. On handshake:
    - rem==1 → IDLE.
    - Otherwise idx+1 (16-bit wrap), rem−1 → ADDR.
- Out-of-range index (≥NUM_SYNAPSES):
  - The read is still issued.
  - The slave's SLVERR is reported through wt_err, with wt_data = whatever rdata[15:0] returns (0 from the memory).
- err_count increments by 1 per non-OKAY response latched in DATA and saturates at 16'hFFFF.
- spk_ready is low outside IDLE; events are never queued.

## Timing
- Reset values: spk_ready=0 during rst, then 1 from the first cycle after release. All other outputs are 0: arvalid, rready, araddr, wt_valid, wt_data, wt_index, wt_last, wt_err, busy, err_count.
- Spike handshake at cycle T → arvalid high at T+1.
- Minimum 3 cycles per weight (ADDR, DATA, OUT), each extended by slave or consumer stalls.
- Next event accepted no earlier than the cycle after the final wt handshake.
- rvalid is ignored outside DATA; arready is ignored outside ADDR.
- wt_ready may be held high early; no combinational path from wt_ready to wt_valid.
- Reset mid-transaction: all state clears immediately and the pending transaction is abandoned. rst is shared with the slave, so no dangling AXI state remains.

## Structure
- Shared package snn_axi_pkg:
  - fetch_state_t enum (IDLE, ADDR, DATA, OUT)
  - AXI_RESP_OKAY=2'b00, AXI_RESP_SLVERR=2'b10
- Single module, no sub-module. An optional output skid buffer is deferred.

## Test plan
- Reset → all outputs 0, spk_ready=1 after release; assert rst during DATA → arvalid/rready/wt_valid drop to 0 asynchronously, next event proceeds normally.
- Event base=5, count=3 against memory preloaded w[5..7]=16'h0011,16'h0022,16'hFFFE:
  - araddr sequence 0x14, 0x18, 0x1C
  - wt_data 0x0011, 0x0022, 0xFFFE; wt_index 5, 6, 7
  - wt_last only on the third weight
  - wt_err=0
- Event base=213, count=2 → index 213 with err=0, then index 214 with wt_err=1, wt_data=0, err_count=1.
- wt_ready held low 10 cycles during OUT → wt_* stable, no new arvalid, spk_ready=0.
- Event count=0 → accepted in 1 cycle, no AXI traffic, busy stays 0.
- Event base=16'hFFFF, count=2 → indices 0xFFFF then 0x0000; both SLVERR/OKAY per range, err_count +1.
